rv32i_imm_unpack: RTL and testbench

RV32I_IMM_UNPACK -- requirements
Module: rv32i_imm_unpack

---
 rtl/rv32i_pkg.sv | 48 ++++
 rtl/rv32i_imm_gen.sv | 42 ++++
 rtl/rv32i_imm_unpack.sv | 135 +++++++++++++
 tb/tb_rv32i_imm_unpack.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I decode constants, instType bit indices and immediate formats
package rv32i_pkg;

    localparam int IT_W       = 11;
    localparam int IT_LOAD    = 0;
    localparam int IT_STORE   = 1;
    localparam int IT_MEMORD  = 2;
    localparam int IT_ALUREG  = 3;
    localparam int IT_ALUIMM  = 4;
    localparam int IT_LUI     = 5;
    localparam int IT_AUIPC   = 6;
    localparam int IT_JAL     = 7;
    localparam int IT_JALR    = 8;
    localparam int IT_BRANCH  = 9;
    localparam int IT_SYSCALL = 10;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Types that write a destination register
    localparam logic [IT_W-1:0] RD_WRITE_MASK = 11'b001_1111_1001;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

    function automatic logic is_onehot(input logic [IT_W-1:0] t);
        return (t != '0) && ((t & (t - 11'd1)) == '0);
    endfunction

    function automatic fmt_e fmt_of(input logic [IT_W-1:0] t);
        if (!is_onehot(t))  return FMT_NONE;
        if (t[IT_STORE])    return FMT_S;
        if (t[IT_BRANCH])   return FMT_B;
        if (t[IT_LUI] || t[IT_AUIPC]) return FMT_U;
        if (t[IT_JAL])      return FMT_J;
        if (t[IT_ALUREG])   return FMT_NONE;
        return FMT_I;
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// rtl/rv32i_imm_gen.sv - combinational deferred-field to immediate/rd/shamt unpacker
module rv32i_imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 5
) (
    input  logic [24:0]          fields_i,
    input  logic [IT_W-1:0]      inst_type_i,
    output logic [XLEN-1:0]      imm_o,
    output logic [REG_COUNT-1:0] rd_o,
    output logic [REG_COUNT-1:0] shamt_o,
    output logic                 rd_write_o,
    output logic                 illegal_o
);

    logic [24:0] f;
    logic [31:0] imm32;
    fmt_e        fmt;

    assign f = fields_i;

    always_comb begin
        fmt   = fmt_of(inst_type_i);
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{f[24]}}, f[24:13]};
            FMT_S:   imm32 = {{20{f[24]}}, f[24:18], f[4:0]};
            FMT_B:   imm32 = {{20{f[24]}}, f[0], f[23:18], f[4:1], 1'b0};
            FMT_U:   imm32 = {f[24:5], 12'b0};
            FMT_J:   imm32 = {{12{f[24]}}, f[12:5], f[13], f[23:14], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o      = XLEN'(signed'(imm32));
    assign rd_o       = REG_COUNT'(f[4:0]);
    assign shamt_o    = REG_COUNT'(f[17:13]);
    assign illegal_o  = !is_onehot(inst_type_i);
    assign rd_write_o = (|(inst_type_i & RD_WRITE_MASK)) && (f[4:0] != 5'd0) && !illegal_o;

endmodule

// File: rtl/rv32i_imm_unpack.sv
// rtl/rv32i_imm_unpack.sv - registered immediate unpack stage; IMM_UNPACK_SKID_EN adds a skid entry
module rv32i_imm_unpack
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 5
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [24:0]          immsRdShamt,
    input  logic [IT_W-1:0]      instType,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      imm,
    output logic [REG_COUNT-1:0] rd,
    output logic [REG_COUNT-1:0] shamt,
    output logic                 rdWrite,
    output logic [IT_W-1:0]      instTypeOut,
    output logic                 illegal
);

    logic [24:0]          gen_f;
    logic [IT_W-1:0]      gen_t;
    logic [XLEN-1:0]      g_imm;
    logic [REG_COUNT-1:0] g_rd, g_shamt;
    logic                 g_rdw, g_ill;

    logic                 accept, load_out;
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      imm_q;
    logic [REG_COUNT-1:0] rd_q, shamt_q;
    logic                 rd_write_q, illegal_q;
    logic [IT_W-1:0]      inst_type_q;

`ifdef IMM_UNPACK_SKID_EN
    logic            skid_valid_q, skid_valid_d, in_ready_q, out_free;
    logic [24:0]     skid_f_q;
    logic [IT_W-1:0] skid_t_q;

    // inReady comes straight from a flop so outReady never reaches it combinationally
    assign inReady  = in_ready_q;
    assign out_free = !out_valid_q || outReady;
    assign accept   = inValid && in_ready_q;
    assign gen_f    = skid_valid_q ? skid_f_q : immsRdShamt;
    assign gen_t    = skid_valid_q ? skid_t_q : instType;
    assign load_out = out_free && (skid_valid_q || accept);

    always_comb begin
        skid_valid_d = skid_valid_q;
        if (skid_valid_q && out_free)
            skid_valid_d = 1'b0;
        else if (accept && !out_free)
            skid_valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            skid_f_q     <= '0;
            skid_t_q     <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (accept && !out_free) begin
                skid_f_q <= immsRdShamt;
                skid_t_q <= instType;
            end
        end
    end
`else
    logic ready_en_q;

    assign inReady  = ready_en_q && (!out_valid_q || outReady);
    assign accept   = inValid && inReady;
    assign gen_f    = immsRdShamt;
    assign gen_t    = instType;
    assign load_out = accept;

    // Keeps inReady low until the first edge after reset release
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) ready_en_q <= 1'b0;
        else       ready_en_q <= 1'b1;
    end
`endif

    rv32i_imm_gen #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_gen (
        .fields_i    (gen_f),
        .inst_type_i (gen_t),
        .imm_o       (g_imm),
        .rd_o        (g_rd),
        .shamt_o     (g_shamt),
        .rd_write_o  (g_rdw),
        .illegal_o   (g_ill)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        if (load_out)      out_valid_d = 1'b1;
        else if (outReady) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            rd_write_q  <= 1'b0;
            inst_type_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load_out) begin
                imm_q       <= g_imm;
                rd_q        <= g_rd;
                shamt_q     <= g_shamt;
                rd_write_q  <= g_rdw;
                inst_type_q <= gen_t;
                illegal_q   <= g_ill;
            end
        end
    end

    assign outValid    = out_valid_q;
    assign imm         = imm_q;
    assign rd          = rd_q;
    assign shamt       = shamt_q;
    assign rdWrite     = rd_write_q;
    assign instTypeOut = inst_type_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_rv32i_imm_unpack.sv
// tb/tb_rv32i_imm_unpack.sv - scoreboard bench for rv32i_imm_unpack against an instruction-level model
module tb_rv32i_imm_unpack;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic        rdw;
        logic [10:0] itype;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [24:0] immsRdShamt = '0;
    logic [10:0] instType = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] imm;
    logic [4:0]  rd, shamt;
    logic        rdWrite;
    logic [10:0] instTypeOut;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   pops = 0;
    int   dropped = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;

`ifdef IMM_UNPACK_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    rv32i_imm_unpack #(.XLEN(32), .REG_COUNT(5)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .inValid     (inValid),
        .inReady     (inReady),
        .immsRdShamt (immsRdShamt),
        .instType    (instType),
        .outValid    (outValid),
        .outReady    (outReady),
        .imm         (imm),
        .rd          (rd),
        .shamt       (shamt),
        .rdWrite     (rdWrite),
        .instTypeOut (instTypeOut),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model works from the reassembled 32-bit instruction word
    function automatic exp_t model(input logic [24:0] f, input logic [10:0] t);
        exp_t        e;
        logic [31:0] ins;
        int          v;
        int          idx;
        ins     = {f, 7'b0};
        e.rd    = ins[11:7];
        e.shamt = ins[24:20];
        e.itype = t;
        e.ill   = ($countones(t) != 1);
        e.imm   = '0;
        e.rdw   = 1'b0;
        v       = 0;
        idx     = 0;
        if (!e.ill) begin
            for (int i = 0; i < 11; i++) if (t[i]) idx = i;
            case (idx)
                0, 2, 4, 8, 10: v = $signed(ins) >>> 20;
                1: begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; end
                9: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (v >= 4096) v -= 8192; end
                5, 6: v = ins & 32'hFFFF_F000;
                7: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (v >= (1 << 20)) v -= (1 << 21); end
                default: v = 0;
            endcase
            e.imm = v;
            e.rdw = (idx inside {0, 3, 4, 5, 6, 7, 8}) && (e.rd != 5'd0);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [24:0] f, input logic [10:0] t,
                                input logic [31:0] i, input logic w, input logic il);
        exp_t e;
        e.imm = i; e.rd = f[4:0]; e.shamt = f[17:13]; e.itype = t; e.rdw = w; e.ill = il;
        return e;
    endfunction

    function automatic logic [10:0] rand_type();
        logic [10:0] t;
        if ($urandom_range(0, 9) != 0) t = 11'd1 << $urandom_range(0, 10);
        else                           t = 11'($urandom);
        return t;
    endfunction

    // Input-side scoreboard push on every handshake
    always @(negedge clk) begin
        if (rstN && inValid && inReady) begin
            sb.push_back(cur_exp);
            acc_cnt++;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (rstN && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=imm %h expected=no output", imm);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                chk("imm", imm, mon_e.imm);
                chk("rd", 32'(rd), 32'(mon_e.rd));
                chk("shamt", 32'(shamt), 32'(mon_e.shamt));
                chk("rdWrite", 32'(rdWrite), 32'(mon_e.rdw));
                chk("instTypeOut", 32'(instTypeOut), 32'(mon_e.itype));
                chk("illegal", 32'(illegal), 32'(mon_e.ill));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) outReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [24:0] f, input logic [10:0] t, input exp_t e);
        int start;
        int n;
        cur_exp     = e;
        immsRdShamt = f;
        instType    = t;
        inValid     = 1'b1;
        start       = acc_cnt;
        n           = 0;
        while (acc_cnt == start && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("accept_within_bound", 32'(acc_cnt != start), 32'd1);
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_within_bound", 32'(sb.size()), 32'd0);
    endtask

    // Holds outReady low for three cycles with inValid high; returns number of accepts
    task automatic stall_fill(output int accepted, input bit check_stable);
        int          start;
        int          seen;
        logic [24:0] f;
        logic [10:0] t;
        logic [31:0] s_imm;
        logic [4:0]  s_rd;
        logic [10:0] s_t;
        outReady    = 1'b0;
        start       = acc_cnt;
        f           = 25'($urandom);
        t           = rand_type();
        cur_exp     = model(f, t);
        immsRdShamt = f;
        instType    = t;
        inValid     = 1'b1;
        seen        = acc_cnt;
        s_imm = '0; s_rd = '0; s_t = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != seen) begin
                seen        = acc_cnt;
                f           = 25'($urandom);
                t           = rand_type();
                cur_exp     = model(f, t);
                immsRdShamt = f;
                instType    = t;
            end
            if (i == 0) begin
                s_imm = imm; s_rd = rd; s_t = instTypeOut;
            end else if (check_stable) begin
                chk("stall_outValid", 32'(outValid), 32'd1);
                chk("stall_imm_stable", imm, s_imm);
                chk("stall_rd_stable", 32'(rd), 32'(s_rd));
                chk("stall_type_stable", 32'(instTypeOut), 32'(s_t));
            end
        end
        inValid  = 1'b0;
        accepted = acc_cnt - start;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic [24:0] f;
        logic [10:0] t;

        // Reset state
        #3;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rdWrite", 32'(rdWrite), 32'd0);
        chk("rst_instTypeOut", 32'(instTypeOut), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("inReady_before_edge", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        chk("inReady_after_edge", 32'(inReady), 32'd1);

        // Directed instruction cases
        f = 25'(32'hFFF00093 >> 7);
        send(f, 11'h010, mk(f, 11'h010, 32'hFFFF_FFFF, 1'b1, 1'b0));
        f = 25'(32'h123452B7 >> 7);
        send(f, 11'h020, mk(f, 11'h020, 32'h1234_5000, 1'b1, 1'b0));
        f = 25'(32'hFE000CE3 >> 7);
        send(f, 11'h200, mk(f, 11'h200, 32'hFFFF_FFF8, 1'b0, 1'b0));
        f = 25'(32'h00500013 >> 7);
        send(f, 11'h010, mk(f, 11'h010, 32'h0000_0005, 1'b0, 1'b0));
        f = 25'h1FFE001;
        send(f, 11'b00000000011, mk(f, 11'b00000000011, 32'h0, 1'b0, 1'b1));
        send(f, 11'h000, mk(f, 11'h000, 32'h0, 1'b0, 1'b1));
        drain();

        // Output stall with continuous input
        stall_fill(acc, 1'b1);
        chk("stall_accepts", 32'(acc), 32'(STALL_ACCEPTS));
        chk("stall_inReady_low", 32'(inReady), 32'd0);
        outReady = 1'b1;
        drain();

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            f = 25'($urandom);
            t = rand_type();
            send(f, t, model(f, t));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        outReady   = 1'b1;
        drain();

        // Reset while holding a result (and a skid entry when present)
        stall_fill(acc, 1'b0);
        chk("prereset_accepts", 32'(acc), 32'(STALL_ACCEPTS));
        #2;
        rstN = 1'b0;
        #1;
        chk("midrst_outValid", 32'(outValid), 32'd0);
        chk("midrst_inReady", 32'(inReady), 32'd0);
        chk("midrst_imm", imm, 32'd0);
        chk("midrst_rdWrite", 32'(rdWrite), 32'd0);
        dropped += sb.size();
        sb.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("postrst_inReady_low", 32'(inReady), 32'd0);
        outReady    = 1'b1;
        f           = 25'($urandom);
        t           = 11'd1 << $urandom_range(0, 10);
        cur_exp     = model(f, t);
        immsRdShamt = f;
        instType    = t;
        inValid     = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_inReady_high", 32'(inReady), 32'd1);
        chk("postrst_outValid_idle", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        chk("postrst_latency1", 32'(outValid), 32'd1);
        drain();

        chk("no_loss_or_dup", 32'(pops + dropped), 32'(acc_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
